// File: rtl/pm_pkg.sv
// Shared constants and state encoding for the parking gate controller.
package pm_pkg;

  localparam int unsigned PIN_W_DEF     = 8;
  localparam logic [7:0]  PIN_VALUE_DEF = 8'h2A;
  localparam int unsigned MAX_TRIES_DEF = 3;
  localparam int unsigned TIMEOUT_DEF   = 16;
  localparam int unsigned CAPACITY_DEF  = 4;
  localparam int unsigned CNT_W_DEF     = 3;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] ST_WAIT_PIN  = 3'd1;
  localparam logic [ST_W-1:0] ST_GATE_OPEN = 3'd2;
  localparam logic [ST_W-1:0] ST_BLOCKED   = 3'd3;
  localparam logic [ST_W-1:0] ST_LOCKOUT   = 3'd4;

  typedef enum logic [ST_W-1:0] {
    IDLE      = ST_IDLE,
    WAIT_PIN  = ST_WAIT_PIN,
    GATE_OPEN = ST_GATE_OPEN,
    BLOCKED   = ST_BLOCKED,
    LOCKOUT   = ST_LOCKOUT
  } state_e;

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Sensor/keypad inputs and gate/alarm outputs of the parking gate controller.
interface parking_gate_ctrl_if
  import pm_pkg::*;
#(
  parameter int unsigned PIN_W = PIN_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             sensorA;
  logic             sensorB;
  logic [PIN_W-1:0] pass;
  logic             passValid;
  logic             exitPulse;
  logic             gateState;
  logic             blockAlarm;
  logic             wrongPinAlarm;
  logic [CNT_W-1:0] occupancy;
  logic             lotFull;

  // Front end / environment side
  modport master (
    output sensorA, sensorB, pass, passValid, exitPulse,
    input  gateState, blockAlarm, wrongPinAlarm, occupancy, lotFull
  );

  // Controller side
  modport slave (
    input  sensorA, sensorB, pass, passValid, exitPulse,
    output gateState, blockAlarm, wrongPinAlarm, occupancy, lotFull
  );

endinterface

// File: rtl/pm_occupancy_counter.sv
// Saturating up/down vehicle counter with a full flag.
module pm_occupancy_counter
  import pm_pkg::*;
#(
  parameter int unsigned CAPACITY = CAPACITY_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full
);

  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;

  assign w_full  = (r_count == CNT_W'(CAPACITY));
  assign w_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_full  = w_full;

  // Simultaneous inc/dec cancel; both ends saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && !w_full) begin
      r_count <= r_count + CNT_W'(1);
    end else if (i_dec && !i_inc && !w_empty) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Single-barrier parking controller: PIN entry, tailgate and lockout alarms, lot occupancy.
module parking_gate_ctrl
  import pm_pkg::*;
#(
  parameter int unsigned      PIN_W     = PIN_W_DEF,
  parameter logic [PIN_W-1:0] PIN_VALUE = PIN_W'(PIN_VALUE_DEF),
  parameter int unsigned      MAX_TRIES = MAX_TRIES_DEF,
  parameter int unsigned      TIMEOUT   = TIMEOUT_DEF,
  parameter int unsigned      CAPACITY  = CAPACITY_DEF,
  parameter int unsigned      CNT_W     = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  parking_gate_ctrl_if.slave  bus
);

  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e           r_state;
  logic [TRY_W-1:0] r_tries;
  logic [TMR_W-1:0] r_timer;
  logic             r_sensor_b_d;
  logic             r_gate;
  logic             r_block;
  logic             r_wpin;

  logic             w_pin_ok;
  logic             w_pin_bad;
  logic [TRY_W-1:0] w_tries_nxt;
  logic             w_timeout;
  logic             w_pass_thru;
  logic             w_full;
  logic [CNT_W-1:0] w_count;

  assign w_pin_ok    = bus.passValid && (bus.pass == PIN_VALUE);
  assign w_pin_bad   = bus.passValid && (bus.pass != PIN_VALUE);
  assign w_tries_nxt = r_tries + TRY_W'(1);
  assign w_timeout   = (r_timer == TMR_W'(TIMEOUT - 1));
  // Vehicle cleared the barrier: sensorB falls while nobody waits at sensorA.
  assign w_pass_thru = (r_state == GATE_OPEN) && !bus.sensorA && r_sensor_b_d && !bus.sensorB;

  // Lot occupancy; a pass-through counts up, an exit strobe counts down.
  pm_occupancy_counter #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) u_occ (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_pass_thru),
    .i_dec   (bus.exitPulse),
    .o_count (w_count),
    .o_full  (w_full)
  );

  // Gate FSM with tries/timer counters and registered gate/alarm outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_tries      <= '0;
      r_timer      <= '0;
      r_sensor_b_d <= 1'b0;
      r_gate       <= 1'b0;
      r_block      <= 1'b0;
      r_wpin       <= 1'b0;
    end else begin
      r_sensor_b_d <= bus.sensorB;
      case (r_state)
        IDLE: begin
          if (bus.sensorA && !w_full) begin
            r_state <= WAIT_PIN;
            r_tries <= '0;
            r_timer <= '0;
          end
        end
        WAIT_PIN: begin
          r_timer <= r_timer + TMR_W'(1);
          if (w_pin_ok) begin
            r_state <= GATE_OPEN;
            r_tries <= '0;
            r_gate  <= 1'b1;
          end else if (w_pin_bad) begin
            r_tries <= w_tries_nxt;
            if (w_tries_nxt == TRY_W'(MAX_TRIES)) begin
              r_state <= LOCKOUT;
              r_wpin  <= 1'b1;
            end
          end else if (!bus.sensorA) begin
            r_state <= IDLE;
          end else if (w_timeout) begin
            r_state <= IDLE;
            r_tries <= '0;
          end
        end
        GATE_OPEN: begin
          if (bus.sensorA && bus.sensorB) begin
            r_state <= BLOCKED;
            r_gate  <= 1'b0;
            r_block <= 1'b1;
          end else if (w_pass_thru) begin
            r_state <= IDLE;
            r_gate  <= 1'b0;
          end
        end
        BLOCKED: begin
          if (w_pin_ok) begin
            r_state <= GATE_OPEN;
            r_gate  <= 1'b1;
            r_block <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (w_pin_ok) begin
            r_state <= GATE_OPEN;
            r_tries <= '0;
            r_gate  <= 1'b1;
            r_wpin  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gate  <= 1'b0;
          r_block <= 1'b0;
          r_wpin  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gateState     = r_gate;
  assign bus.blockAlarm    = r_block;
  assign bus.wrongPinAlarm = r_wpin;
  assign bus.occupancy     = w_count;
  assign bus.lotFull       = w_full;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl: directed steps push expectations, a negedge monitor checks them.
module tb_parking_gate_ctrl;
  import pm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  parking_gate_ctrl_if bus ();

  parking_gate_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         due;
    string      name;
    logic       gate;
    logic       blk;
    logic       wpa;
    logic [2:0] occ;
    logic       full;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s cyc=%0d gate/blk/wpa/full/occ got=%b_%b_%b_%b_%0d expected=%b_%b_%b_%b_%0d",
               name, cyc, act[6], act[5], act[4], act[3], act[2:0],
               expv[6], expv[5], expv[4], expv[3], expv[2:0]);
    end
  endtask

  // Monitor: compare every expectation that falls due this cycle.
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [6:0] act;
    logic [6:0] expv;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      act  = {bus.gateState, bus.blockAlarm, bus.wrongPinAlarm, bus.lotFull, bus.occupancy};
      expv = {e.gate, e.blk, e.wpa, e.full, e.occ};
      if (e.due < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s stale expectation due=%0d now=%0d", e.name, e.due, cyc);
      end else begin
        check(e.name, act, expv);
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input logic sa, input logic sb, input logic pv, input logic [7:0] pin,
                      input logic ex, input string name, input logic gate, input logic blk,
                      input logic wpa, input logic [2:0] occ);
    exp_t e;
    bus.sensorA   = sa;
    bus.sensorB   = sb;
    bus.passValid = pv;
    bus.pass      = pin;
    bus.exitPulse = ex;
    e.due  = cyc + 1;
    e.name = name;
    e.gate = gate;
    e.blk  = blk;
    e.wpa  = wpa;
    e.occ  = occ;
    e.full = (occ == 3'd4);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Full admission: arrive, correct PIN, drive through, sensorB falls.
  task automatic admit(input logic [2:0] occ_before);
    step(1, 0, 0, 8'h00, 0, "adm_enter", 0, 0, 0, occ_before);
    step(1, 0, 1, 8'h2A, 0, "adm_pin",   1, 0, 0, occ_before);
    step(0, 1, 0, 8'h00, 0, "adm_sb1",   1, 0, 0, occ_before);
    step(0, 0, 0, 8'h00, 0, "adm_pass",  0, 0, 0, occ_before + 3'd1);
  endtask

  initial begin
    bus.sensorA   = 1'b0;
    bus.sensorB   = 1'b0;
    bus.passValid = 1'b0;
    bus.pass      = 8'h00;
    bus.exitPulse = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    step(0, 0, 0, 8'h00, 0, "reset_state", 0, 0, 0, 3'd0);

    // Normal entry
    step(1, 0, 0, 8'h00, 0, "norm_enter", 0, 0, 0, 3'd0);
    step(1, 0, 1, 8'h2A, 0, "norm_pin",   1, 0, 0, 3'd0);
    step(0, 1, 0, 8'h00, 0, "norm_sb1",   1, 0, 0, 3'd0);
    step(0, 0, 0, 8'h00, 0, "norm_pass",  0, 0, 0, 3'd1);
    step(0, 0, 0, 8'h00, 0, "norm_idle",  0, 0, 0, 3'd1);

    // Lockout after three wrong PINs
    step(1, 0, 0, 8'h00, 0, "lk_enter",     0, 0, 0, 3'd1);
    step(1, 0, 1, 8'h00, 0, "lk_wrong1",    0, 0, 0, 3'd1);
    step(1, 0, 1, 8'h01, 0, "lk_wrong2",    0, 0, 0, 3'd1);
    step(1, 0, 1, 8'h02, 0, "lk_wrong3",    0, 0, 1, 3'd1);
    step(0, 1, 0, 8'h00, 0, "lk_sensors",   0, 0, 1, 3'd1);
    step(0, 0, 1, 8'h55, 0, "lk_wrong4",    0, 0, 1, 3'd1);
    step(1, 0, 1, 8'h2A, 0, "lk_unlock",    1, 0, 0, 3'd1);
    step(0, 1, 0, 8'h00, 0, "lk_sb1",       1, 0, 0, 3'd1);
    step(0, 0, 0, 8'h00, 0, "lk_pass",      0, 0, 0, 3'd2);

    // Two wrong PINs stay below the lockout limit
    step(1, 0, 0, 8'h00, 0, "tr_enter",  0, 0, 0, 3'd2);
    step(1, 0, 1, 8'h00, 0, "tr_wrong1", 0, 0, 0, 3'd2);
    step(1, 0, 1, 8'h01, 0, "tr_wrong2", 0, 0, 0, 3'd2);
    step(1, 0, 1, 8'h2A, 0, "tr_pin",    1, 0, 0, 3'd2);

    // Tailgate
    step(1, 1, 0, 8'h00, 0, "tg_block",   0, 1, 0, 3'd2);
    step(1, 1, 1, 8'h00, 0, "tg_wrong",   0, 1, 0, 3'd2);
    step(0, 0, 1, 8'h2A, 0, "tg_clear",   1, 0, 0, 3'd2);
    step(0, 1, 0, 8'h00, 0, "tg_sb1",     1, 0, 0, 3'd2);
    step(0, 0, 0, 8'h00, 0, "tg_pass",    0, 0, 0, 3'd3);

    // Timeout: 16 cycles in WAIT_PIN, then IDLE ignores a PIN and re-enters
    step(1, 0, 0, 8'h00, 0, "to_enter", 0, 0, 0, 3'd3);
    for (int i = 0; i < 15; i++) step(1, 0, 0, 8'h00, 0, "to_wait", 0, 0, 0, 3'd3);
    step(1, 0, 0, 8'h00, 0, "to_expire",  0, 0, 0, 3'd3);
    step(1, 0, 1, 8'h2A, 0, "to_idlepin", 0, 0, 0, 3'd3);
    step(1, 0, 1, 8'h2A, 0, "to_reenter", 1, 0, 0, 3'd3);
    step(0, 1, 0, 8'h00, 0, "to_sb1",     1, 0, 0, 3'd3);
    step(0, 0, 0, 8'h00, 0, "to_pass",    0, 0, 0, 3'd4);

    // Full lot refuses entry
    step(1, 0, 0, 8'h00, 0, "full_arrive", 0, 0, 0, 3'd4);
    step(1, 0, 1, 8'h2A, 0, "full_pin",    0, 0, 0, 3'd4);
    step(0, 0, 0, 8'h00, 1, "full_exit",   0, 0, 0, 3'd3);

    // Correct PIN on the last WAIT_PIN cycle beats the timeout
    step(1, 0, 0, 8'h00, 0, "tb_enter", 0, 0, 0, 3'd3);
    for (int i = 0; i < 15; i++) step(1, 0, 0, 8'h00, 0, "tb_wait", 0, 0, 0, 3'd3);
    step(1, 0, 1, 8'h2A, 0, "tb_lastpin", 1, 0, 0, 3'd3);
    step(0, 1, 0, 8'h00, 0, "tb_sb1",     1, 0, 0, 3'd3);
    // Pass-through and exit in the same cycle
    step(0, 0, 0, 8'h00, 1, "simul_pass_exit", 0, 0, 0, 3'd3);

    // Drain the lot, then an exit at zero is ignored
    step(0, 0, 0, 8'h00, 1, "exit_2", 0, 0, 0, 3'd2);
    step(0, 0, 0, 8'h00, 1, "exit_1", 0, 0, 0, 3'd1);
    step(0, 0, 0, 8'h00, 1, "exit_0", 0, 0, 0, 3'd0);
    step(0, 0, 0, 8'h00, 1, "exit_at_zero", 0, 0, 0, 3'd0);

    // Asynchronous reset while the gate is open with two cars parked
    admit(3'd0);
    admit(3'd1);
    step(1, 0, 0, 8'h00, 0, "rst_enter", 0, 0, 0, 3'd2);
    step(1, 0, 1, 8'h2A, 0, "rst_open",  1, 0, 0, 3'd2);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", {bus.gateState, bus.blockAlarm, bus.wrongPinAlarm, bus.lotFull, bus.occupancy}, 7'b0);
    bus.sensorA   = 1'b0;
    bus.passValid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 8'h00, 0, "post_reset", 0, 0, 0, 3'd0);

    // Bounded drain of outstanding expectations
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain pending=%0d expected=0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
